// File: rtl/regfile_pkg.sv
// Shared widths, constants and bus types for the general-purpose register file.
package regfile_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef logic [DATA_W-1:0] reg_bus_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_bus_t  ZERO_WORD = '0;
  localparam reg_addr_t ZERO_ADDR = '0;
  localparam reg_addr_t LAST_IDX  = reg_addr_t'(NUM_REGS - 1);

endpackage

// File: rtl/regfile.sv
// Register file: two bypassed combinational read ports, one write port, post-reset clear sweep
// and a req/ack debug read port. The array itself carries no reset so it can map onto RAM.
module regfile
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      we,
  input  reg_addr_t waddr,
  input  reg_bus_t  wdata,
  input  logic      re1,
  input  reg_addr_t raddr1,
  output reg_bus_t  rdata1,
  input  logic      re2,
  input  reg_addr_t raddr2,
  output reg_bus_t  rdata2,
  output logic      init_busy,
  input  logic      dbg_req,
  input  reg_addr_t dbg_addr,
  output logic      dbg_ack,
  output reg_bus_t  dbg_data
);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0] state;
  reg_addr_t  idx;
  reg_bus_t   mem [NUM_REGS];
  logic       run;
  logic       dbg_accept;

  // Shared by both read ports and the debug port: $0, then same-cycle write bypass, then array.
  function automatic reg_bus_t lookup(input reg_addr_t a, input logic w_en,
                                      input reg_addr_t w_addr, input reg_bus_t w_data,
                                      input reg_bus_t stored);
    if (a == ZERO_ADDR)
      return ZERO_WORD;
    if (w_en && (w_addr == a))
      return w_data;
    return stored;
  endfunction

  assign run        = (state == ST_RUN) && !rst;
  assign init_busy  = (state == ST_INIT);
  assign dbg_accept = run && dbg_req && !dbg_ack;

  assign rdata1 = (run && re1) ? lookup(raddr1, we, waddr, wdata, mem[raddr1]) : ZERO_WORD;
  assign rdata2 = (run && re2) ? lookup(raddr2, we, waddr, wdata, mem[raddr2]) : ZERO_WORD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INIT;
      idx   <= reg_addr_t'(1);
    end else if (state == ST_INIT) begin
      idx <= idx + reg_addr_t'(1);
      if (idx == LAST_IDX)
        state <= ST_RUN;
    end
  end

  // Single array write port shared by the clear sweep and write-back; entry 0 is never written.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT)
        mem[idx] <= ZERO_WORD;
      else if (we && (waddr != ZERO_ADDR))
        mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_ack  <= 1'b0;
      dbg_data <= ZERO_WORD;
    end else begin
      dbg_ack <= dbg_accept;
      if (dbg_accept)
        dbg_data <= lookup(dbg_addr, we, waddr, wdata, mem[dbg_addr]);
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: vector table, multi-cycle corner sequences, and
// randomized traffic against an array-based reference model.
module tb_regfile;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        re1 = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic [31:0] rdata1;
  logic        re2 = 1'b0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata2;
  logic        init_busy;
  logic        dbg_req = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic        dbg_ack;
  logic [31:0] dbg_data;

  regfile dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .init_busy(init_busy),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ack(dbg_ack), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: architectural contents, edges left in the clear sweep, debug outputs.
  logic [31:0] m_mem [32];
  int          m_sweep_left;
  logic        m_ack;
  logic [31:0] m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (we && waddr == a) return wdata;
    return m_mem[a];
  endfunction

  // One clock cycle: called at posedge+1 with inputs already driven, returns at next posedge+1.
  task automatic cyc();
    logic        running;
    logic        nack;
    logic [31:0] ndata;
    #1;
    running = !rst && (m_sweep_left == 0);
    check("rdata1", rdata1, (running && re1) ? ref_read(raddr1) : 32'h0);
    check("rdata2", rdata2, (running && re2) ? ref_read(raddr2) : 32'h0);
    check("init_busy", {31'h0, init_busy}, {31'h0, !running});
    check("dbg_ack", {31'h0, dbg_ack}, {31'h0, m_ack});
    check("dbg_data", dbg_data, m_data);
    nack  = running && dbg_req && !m_ack;
    ndata = nack ? ref_read(dbg_addr) : m_data;
    @(posedge clk);
    if (!rst) begin
      if (running && we && waddr != 5'd0) m_mem[waddr] = wdata;
      if (m_sweep_left > 0) m_sweep_left--;
      m_ack  = nack;
      m_data = ndata;
    end
    #1;
  endtask

  // Asynchronous reset pulse asserted mid-cycle; returns at posedge+1 with rst released.
  task automatic do_reset();
    #3;
    rst = 1'b1;
    re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd5; raddr2 = 5'd9;
    m_sweep_left = 31;
    m_ack = 1'b0;
    m_data = 32'h0;
    for (int i = 0; i < 32; i++) m_mem[i] = 32'h0;
    #1;
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_rdata2", rdata2, 32'h0);
    check("rst_busy", {31'h0, init_busy}, 32'h1);
    check("rst_ack", {31'h0, dbg_ack}, 32'h0);
    check("rst_dbg_data", dbg_data, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    re1 = 1'b0; re2 = 1'b0;
  endtask

  task automatic idle();
    we = 1'b0; re1 = 1'b0; re2 = 1'b0; dbg_req = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int busy_cnt;
    int first_idle;
    int first_ack;

    vecs[0] = '{1'b1, 5'd5, 32'h1234ABCD, 1'b0, 5'd5, 1'b0, 5'd0, 32'h0, 32'h0};
    vecs[1] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 1'b0, 5'd5, 32'h1234ABCD, 32'h0};
    vecs[2] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd5, 1'b1, 5'd5, 32'h0, 32'h1234ABCD};
    vecs[3] = '{1'b1, 5'd7, 32'hDEADBEEF, 1'b1, 5'd7, 1'b1, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd7, 32'h0, 32'hDEADBEEF};
    vecs[5] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 1'b1, 5'd0, 32'h0, 32'h0};
    vecs[6] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b1, 5'd5, 32'hDEADBEEF, 32'h1234ABCD};
    vecs[7] = '{1'b1, 5'd5, 32'h55AA55AA, 1'b1, 5'd5, 1'b1, 5'd31, 32'h55AA55AA, 32'h0};

    @(posedge clk);
    #1;
    do_reset();

    // Sweep length and post-sweep contents.
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (init_busy) busy_cnt++;
      cyc();
    end
    check("t1_busy_cycles", busy_cnt, 31);
    for (int a = 1; a < 32; a++) begin
      re1 = 1'b1; re2 = 1'b1; raddr1 = 5'(a); raddr2 = 5'(a);
      #1;
      check("t1_rd1_zero", rdata1, 32'h0);
      check("t1_rd2_zero", rdata2, 32'h0);
      dbg_req = 1'b1; dbg_addr = 5'(a);
      cyc();
      dbg_req = 1'b0; re1 = 1'b0; re2 = 1'b0;
      cyc();
    end

    // Write/read and bypass vectors.
    for (int v = 0; v < 8; v++) begin
      we = vecs[v].we; waddr = vecs[v].waddr; wdata = vecs[v].wdata;
      re1 = vecs[v].re1; raddr1 = vecs[v].raddr1;
      re2 = vecs[v].re2; raddr2 = vecs[v].raddr2;
      #1;
      check("vec_rdata1", rdata1, vecs[v].exp1);
      check("vec_rdata2", rdata2, vecs[v].exp2);
      cyc();
    end
    idle();
    cyc();

    // Debug handshake with held request.
    we = 1'b1; waddr = 5'd9; wdata = 32'hCAFEF00D;
    cyc();
    we = 1'b0; dbg_req = 1'b1; dbg_addr = 5'd9;
    cyc();
    check("t5_ack1", {31'h0, dbg_ack}, 32'h1);
    check("t5_data1", dbg_data, 32'hCAFEF00D);
    cyc();
    check("t5_ack_gap", {31'h0, dbg_ack}, 32'h0);
    cyc();
    check("t5_ack2", {31'h0, dbg_ack}, 32'h1);
    dbg_req = 1'b0;
    cyc();
    cyc();

    // Randomized traffic, biased toward a few addresses so bypass collisions happen.
    for (int n = 0; n < 400; n++) begin
      we     = ($urandom_range(0, 1) == 1);
      waddr  = 5'($urandom_range(0, 7));
      wdata  = $urandom;
      re1    = ($urandom_range(0, 3) != 0);
      raddr1 = 5'($urandom_range(0, 7));
      re2    = ($urandom_range(0, 3) != 0);
      raddr2 = ($urandom_range(0, 3) == 0) ? raddr1 : 5'($urandom_range(0, 31));
      if (!dbg_req || dbg_ack) begin
        dbg_req  = ($urandom_range(0, 2) != 0);
        dbg_addr = ($urandom_range(0, 1) == 1) ? waddr : 5'($urandom_range(0, 31));
      end
      cyc();
    end
    idle();
    cyc();

    // Reset mid-sweep restarts it; writes and debug requests during the sweep are held off.
    do_reset();
    we = 1'b1; waddr = 5'd3; wdata = 32'h33333333;
    for (int i = 0; i < 9; i++) cyc();
    do_reset();
    busy_cnt = 0; first_idle = -1; first_ack = -1;
    dbg_req = 1'b1; dbg_addr = 5'd9;
    for (int i = 0; i < 40; i++) begin
      we = (i < 20); waddr = 5'd3; wdata = 32'h33333333;
      if (init_busy) busy_cnt++;
      else if (first_idle < 0) first_idle = i;
      if (dbg_ack && first_ack < 0) first_ack = i;
      cyc();
    end
    check("t4_busy_cycles", busy_cnt, 31);
    check("t5_ack_after_init", first_ack, first_idle + 1);
    idle();
    re1 = 1'b1; raddr1 = 5'd3;
    #1;
    check("t4_reg3_zero", rdata1, 32'h0);
    cyc();
    idle();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
